sdfm_comp_thr: RTL
==================

Name: sdfm_comp_thr

Overview:
Threshold detector directly downstream of the comparator filter unit in the sigma-delta filter module. It consumes each filtered comparator sample (comp_data_out with its one-SYSCLK update strobe) and compares it against programmable high and low limits. Each side has a consecutive-sample qualifier. The block produces latched/hardware-cleared trip flags and a single-cycle interrupt request to the register/interrupt block.

Parameters:
DW, 32, comparator sample and threshold width (two's-complement signed)
CW, 4, qualifier counter width (max consecutive count 2^CW-1)

Ports:
SYSCLK  in  1  system clock
SYSRSTn  in  1  asynchronous active-low reset
comp_data_in  in  DW  filtered comparator sample, signed
comp_data_update  in  1  one-cycle strobe, sample valid
reg_comphen  in  1  high-limit comparator enable
reg_complen  in  1  low-limit comparator enable
reg_comphclrflg  in  1  1: flags hardware-cleared when condition ends; 0: flags latched until software clear
reg_hlt  in  DW  high threshold, signed
reg_llt  in  DW  low threshold, signed
reg_cmpfltn  in  CW  consecutive-sample count required to trip (0 treated as 1)
reg_clrh  in  1  one-cycle software clear of high flag
reg_clrl  in  1  one-cycle software clear of low flag
reg_intenh  in  1  high-flag interrupt enable
reg_intenl  in  1  low-flag interrupt enable
comp_hflag  out  1  high-limit trip flag
comp_lflag  out  1  low-limit trip flag
comp_hqual  out  1  high condition currently qualified (live status)
comp_lqual  out  1  low condition currently qualified
comp_irq  out  1  one-SYSCLK interrupt pulse
comp_sample  out  DW  last sample accepted on update

Behaviour:
- Reset is SYSRSTn, asynchronous, active-low. Clock is SYSCLK. All state is in the SYSCLK domain.
- Reset values: all outputs 0, counters 0, comp_sample 0.
- Raw compare, combinational on the input:
  - hi_raw = comp_data_in > reg_hlt (signed, strict).
  - lo_raw = comp_data_in < reg_llt (signed, strict).
- Per side, at the edge where comp_data_update=1 (cycle T):
  - If the side is enabled: raw=1 → cnt <= sat(cnt+1, Nq); raw=0 → cnt <= 0.
  - Nq = max(reg_cmpfltn, 1).
  - Saturation: cnt never exceeds Nq and never wraps.
  - comp_sample <= comp_data_in. The sample updates regardless of enables.
- Without an update strobe the counters hold. Threshold changes take effect at the next update only.
- qual registered with cnt at the same edge: qual = (next cnt >= Nq). Visible at T+1.
- Lowering reg_cmpfltn below the current cnt: qual is re-evaluated at the next update.
- Flag state machine per side, states CLEAR and TRIPPED, evaluated every cycle from qual:
  - CLEAR→TRIPPED when qual=1. Flag visible at T+2 after the tripping update.
  - TRIPPED→CLEAR when the software clear pulses, or when reg_comphclrflg=1 and qual=0.
  - Software clear while qual=1 (latched mode): set wins and the flag stays 1. The clear is lost, not deferred.
  - Switching reg_comphclrflg from 0 to 1 while qual=0 clears the flag on the next cycle.
- Side disable (enable=0): next cycle cnt=0, qual=0, flag=0. No irq is generated.
- comp_irq: 1 for exactly one cycle, in the same cycle the flag first reads 1 (T+2), for that side's CLEAR→TRIPPED transition with its inten=1.
  - Both sides tripping in the same cycle give a single pulse.
  - Re-trips after a clear pulse again.
  - inten is sampled at the transition edge. Enabling inten while already TRIPPED gives no pulse.
- Thresholds with llt > hlt are legal. Both sides may trip on one sample.
- A back-to-back update on every cycle is supported. Throughput is 1 sample/cycle.
- Reset mid-operation returns everything to reset values immediately. No pulse is emitted after reset.

Decomposition:
- Package sdfm_comp_pkg:
  - DW/CW defaults.
  - Flag state encoding (ST_CLEAR=1'b0, ST_TRIPPED=1'b1).
  - Compare-direction constants CMP_GT/CMP_LT.
- Sub-module sdfm_comp_thr_side, instantiated twice with a direction parameter. It contains the compare, qualifier counter, qual register, flag FSM and rising-edge detect.
- The top holds the sample register and the irq OR.

Test Plan:
1. Nq=1, hlt=100, en_h=1, inten_h=1, latched mode; update with data=101 at T → qual_h=1 at T+1; hflag=1 and irq pulse at T+2 only. Data=100 → no trip (strict compare).
2. Nq=3, llt=-50; updates -60,-60,0,-60,-60,-60 → lflag stays 0 until the 6th update, then sets; the counter resets on 0. cnt saturates at 3 on further -60 samples.
3. Hardware-clear mode, hflag tripped; next update data=0 → qual_h=0, hflag=0 one cycle later. Re-trip with 200 → second irq pulse.
4. Latched mode, qual_h=1, pulse reg_clrh → hflag stays 1. Drop data below hlt, then reg_clrh → hflag=0 next cycle, no irq.
5. llt=10, hlt=-10, both enabled with ints, data=0 → both flags set in the same cycle, exactly one irq pulse. Disable en_l → lflag=0 next cycle.
6. Assert SYSRSTn=0 mid-count (cnt=2, flags set) → all outputs 0 asynchronously. After release, no irq until a new qualified trip.

Source files
------------

// File: rtl/sdfm_comp_pkg.sv
// sdfm_comp_pkg: shared widths, flag state encoding and compare directions
// for the comparator threshold detector.
package sdfm_comp_pkg;
    localparam int DW_DEF = 32;
    localparam int CW_DEF = 4;
    typedef enum logic {ST_CLEAR = 1'b0, ST_TRIPPED = 1'b1} flag_st_t;
    typedef enum logic {CMP_GT = 1'b0, CMP_LT = 1'b1} cmp_dir_t;
endpackage

// File: rtl/sdfm_comp_thr_side.sv
// sdfm_comp_thr_side: one limit side -- compare, consecutive-sample qualifier,
// trip flag FSM and a registered pulse on each CLEAR->TRIPPED transition.
module sdfm_comp_thr_side
    import sdfm_comp_pkg::*;
#(
    parameter int       DW  = DW_DEF,
    parameter int       CW  = CW_DEF,
    parameter cmp_dir_t DIR = CMP_GT
) (
    input  logic                 SYSCLK,
    input  logic                 SYSRSTn,
    input  logic signed [DW-1:0] data,
    input  logic signed [DW-1:0] thr,
    input  logic                 update,
    input  logic                 en,
    input  logic                 hclr,
    input  logic        [CW-1:0] fltn,
    input  logic                 clr,
    input  logic                 inten,
    output logic                 flag,
    output logic                 qual,
    output logic                 rise
);
    logic          raw;
    logic [CW-1:0] nq, cnt, cnt_nxt;
    flag_st_t      st, st_nxt;

    assign nq      = (fltn == '0) ? CW'(1) : fltn;
    assign raw     = (DIR == CMP_GT) ? (data > thr) : (data < thr);
    // Saturate at Nq, which also pulls cnt down if Nq was lowered below it.
    assign cnt_nxt = !raw ? '0 : (cnt >= nq) ? nq : cnt + 1'b1;

    always_ff @(posedge SYSCLK or negedge SYSRSTn) begin
        if (!SYSRSTn) begin
            cnt  <= '0;
            qual <= 1'b0;
        end else if (!en) begin
            cnt  <= '0;
            qual <= 1'b0;
        end else if (update) begin
            cnt  <= cnt_nxt;
            qual <= (cnt_nxt >= nq);
        end
    end

    always_ff @(posedge SYSCLK or negedge SYSRSTn) begin
        if (!SYSRSTn) begin
            st   <= ST_CLEAR;
            rise <= 1'b0;
        end else begin
            st   <= st_nxt;
            rise <= (st == ST_CLEAR) && (st_nxt == ST_TRIPPED) && inten;
        end
    end

    // A live qualified condition always beats a clear request.
    always_comb begin
        st_nxt = !en ? ST_CLEAR
               : (st == ST_CLEAR) ? (qual ? ST_TRIPPED : ST_CLEAR)
               : (!qual && (clr || hclr)) ? ST_CLEAR : ST_TRIPPED;
    end

    always_comb begin
        flag = (st == ST_TRIPPED);
    end
endmodule

// File: rtl/sdfm_comp_thr.sv
// sdfm_comp_thr: high/low threshold detector on filtered comparator samples,
// producing trip flags, live qualifier status and a combined interrupt pulse.
module sdfm_comp_thr
    import sdfm_comp_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int CW = CW_DEF
) (
    input  logic                 SYSCLK,
    input  logic                 SYSRSTn,
    input  logic signed [DW-1:0] comp_data_in,
    input  logic                 comp_data_update,
    input  logic                 reg_comphen,
    input  logic                 reg_complen,
    input  logic                 reg_comphclrflg,
    input  logic signed [DW-1:0] reg_hlt,
    input  logic signed [DW-1:0] reg_llt,
    input  logic        [CW-1:0] reg_cmpfltn,
    input  logic                 reg_clrh,
    input  logic                 reg_clrl,
    input  logic                 reg_intenh,
    input  logic                 reg_intenl,
    output logic                 comp_hflag,
    output logic                 comp_lflag,
    output logic                 comp_hqual,
    output logic                 comp_lqual,
    output logic                 comp_irq,
    output logic        [DW-1:0] comp_sample
);
    logic rise_h, rise_l;

    sdfm_comp_thr_side #(.DW(DW), .CW(CW), .DIR(CMP_GT)) u_hi (
        .SYSCLK (SYSCLK),
        .SYSRSTn(SYSRSTn),
        .data   (comp_data_in),
        .thr    (reg_hlt),
        .update (comp_data_update),
        .en     (reg_comphen),
        .hclr   (reg_comphclrflg),
        .fltn   (reg_cmpfltn),
        .clr    (reg_clrh),
        .inten  (reg_intenh),
        .flag   (comp_hflag),
        .qual   (comp_hqual),
        .rise   (rise_h)
    );

    sdfm_comp_thr_side #(.DW(DW), .CW(CW), .DIR(CMP_LT)) u_lo (
        .SYSCLK (SYSCLK),
        .SYSRSTn(SYSRSTn),
        .data   (comp_data_in),
        .thr    (reg_llt),
        .update (comp_data_update),
        .en     (reg_complen),
        .hclr   (reg_comphclrflg),
        .fltn   (reg_cmpfltn),
        .clr    (reg_clrl),
        .inten  (reg_intenl),
        .flag   (comp_lflag),
        .qual   (comp_lqual),
        .rise   (rise_l)
    );

    always_ff @(posedge SYSCLK or negedge SYSRSTn) begin
        if (!SYSRSTn)              comp_sample <= '0;
        else if (comp_data_update) comp_sample <= comp_data_in;
    end

    assign comp_irq = rise_h | rise_l;
endmodule
